uart_alu_ctrl: RTL and testbench

- Sequencer between the UART receiver/transmitter pair and the combinational ALU inside the top-level design.
- Collects three bytes from the UART receiver in order: operand A, operand B, opcode. Drives them as registered values onto the ALU, then hands the ALU result to the UART transmitter as one byte.
- Detects inter-byte timeouts and receive overruns so a corrupted host frame cannot desynchronise the byte sequence.

---
 rtl/uart_alu_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// Purpose : sequences three UART bytes (A, B, opcode) onto the ALU and sends the ALU result back.
// Latency : opcode rx_done_tick sampled at edge N -> tx_start high in cycle N+2 (one CALC cycle).
// Backpressure: no stalls; bytes arriving while busy are dropped and flagged by sticky overrun.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   rx_done_tick, rx_data - received byte strobe and data
//   tx_done_tick          - transmitter finished the current byte
//   alu_result            - combinational ALU output computed from alu_a/alu_b/alu_op
//   alu_a, alu_b, alu_op  - registered ALU operands / opcode
//   tx_start, tx_data     - one-cycle start pulse and byte to send (held until tx_done_tick)
//   busy                  - high while computing or transmitting
//   overrun               - sticky flag: a received byte was dropped
//   timeout_tick          - one-cycle pulse when a partial frame is abandoned
module uart_alu_ctrl #(
    parameter int DATA_BITS      = 8,
    parameter int OP_BITS        = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_done_tick,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 tx_done_tick,
    input  logic [DATA_BITS-1:0] alu_result,
    output logic [DATA_BITS-1:0] alu_a,
    output logic [DATA_BITS-1:0] alu_b,
    output logic [OP_BITS-1:0]   alu_op,
    output logic                 tx_start,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_tick
);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_CALC,
        S_WAIT_TX
    } state_t;

    // Counter only ever needs to reach TIMEOUT_CYCLES-1.
    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [DATA_BITS-1:0] alu_a_nxt, alu_b_nxt, tx_data_nxt;
    logic [OP_BITS-1:0]   alu_op_nxt;
    logic                 tx_start_nxt, overrun_nxt, timeout_nxt;
    logic                 expired;

    assign expired = TO_EN && (cnt == CNT_LAST);
    assign busy    = (state == S_CALC) || (state == S_WAIT_TX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_WAIT_A;
            cnt          <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            tx_data      <= '0;
            tx_start     <= 1'b0;
            overrun      <= 1'b0;
            timeout_tick <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            alu_a        <= alu_a_nxt;
            alu_b        <= alu_b_nxt;
            alu_op       <= alu_op_nxt;
            tx_data      <= tx_data_nxt;
            tx_start     <= tx_start_nxt;
            overrun      <= overrun_nxt;
            timeout_tick <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = '0;          // cleared unless a waiting state counts up
        alu_a_nxt    = alu_a;
        alu_b_nxt    = alu_b;
        alu_op_nxt   = alu_op;
        tx_data_nxt  = tx_data;
        tx_start_nxt = 1'b0;
        overrun_nxt  = overrun;
        timeout_nxt  = 1'b0;

        case (state)
            S_WAIT_A: begin
                if (rx_done_tick) begin
                    alu_a_nxt = rx_data;
                    state_nxt = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                // A byte on the expiry cycle wins over the timeout.
                if (rx_done_tick) begin
                    alu_b_nxt = rx_data;
                    state_nxt = S_WAIT_OP;
                end else if (expired) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_WAIT_A;
                end else if (TO_EN) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT_OP: begin
                if (rx_done_tick) begin
                    alu_op_nxt = rx_data[OP_BITS-1:0];
                    state_nxt  = S_CALC;
                end else if (expired) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_WAIT_A;
                end else if (TO_EN) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_CALC: begin
                // ALU has had a full cycle to settle on the registered operands.
                tx_data_nxt  = alu_result;
                tx_start_nxt = 1'b1;
                state_nxt    = S_WAIT_TX;
                if (rx_done_tick) begin
                    overrun_nxt = 1'b1;
                end
            end
            S_WAIT_TX: begin
                if (tx_done_tick) begin
                    // A byte coinciding with tx completion starts the next frame.
                    if (rx_done_tick) begin
                        alu_a_nxt = rx_data;
                        state_nxt = S_WAIT_B;
                    end else begin
                        state_nxt = S_WAIT_A;
                    end
                end else if (rx_done_tick) begin
                    overrun_nxt = 1'b1;
                end
            end
            default: state_nxt = S_WAIT_A;
        endcase
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed scenarios followed by random frames, with
// expected results computed from the bytes sent through a simple ALU model.
module tb_uart_alu_ctrl;

    localparam int DB = 8;
    localparam int OB = 6;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_done_tick;
    logic [DB-1:0] rx_data;
    logic          tx_done_tick;
    logic [DB-1:0] alu_result;
    logic [DB-1:0] alu_a, alu_b, tx_data;
    logic [OB-1:0] alu_op;
    logic          tx_start, busy, overrun, timeout_tick;

    int errors = 0;
    int checks = 0;

    logic [7:0] ra, rb, ro, ex;
    int         g1, g2, hold, pulses;
    logic [7:0] op_tab [5];

    uart_alu_ctrl #(
        .DATA_BITS     (DB),
        .OP_BITS       (OB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_done_tick(rx_done_tick),
        .rx_data     (rx_data),
        .tx_done_tick(tx_done_tick),
        .alu_result  (alu_result),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_tick(timeout_tick)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor.
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'hA5 ^ a;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_txd);
        rx_data      = b;
        rx_done_tick = 1'b1;
        tx_done_tick = with_txd;
        step();
        rx_done_tick = 1'b0;
        tx_done_tick = 1'b0;
        rx_data      = 8'($urandom);   // idle garbage must be ignored
    endtask

    // Called right after the opcode byte edge; ends in the 2nd WAIT_TX cycle.
    task automatic expect_tx(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opb);
        logic [7:0] exp;
        exp = alu_model(a, b, opb[5:0]);
        check({tag, ".alu_a"}, alu_a, a);
        check({tag, ".alu_b"}, alu_b, b);
        check({tag, ".alu_op"}, alu_op, opb[5:0]);
        check({tag, ".calc_busy"}, busy, 1'b1);
        check({tag, ".calc_txs"}, tx_start, 1'b0);
        step();
        check({tag, ".tx_start"}, tx_start, 1'b1);
        check({tag, ".tx_data"}, tx_data, exp);
        step();
        check({tag, ".tx_start_low"}, tx_start, 1'b0);
        check({tag, ".tx_busy"}, busy, 1'b1);
    endtask

    task automatic finish_tx(input string tag, input logic [7:0] exp, input int hold_n);
        repeat (hold_n) begin
            step();
            check({tag, ".hold"}, {tx_start, tx_data}, {1'b0, exp});
        end
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        check({tag, ".idle_busy"}, busy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".alu_a"}, alu_a, 8'h00);
        check({tag, ".alu_b"}, alu_b, 8'h00);
        check({tag, ".alu_op"}, alu_op, 6'h00);
        check({tag, ".tx_data"}, tx_data, 8'h00);
        check({tag, ".flags"}, {tx_start, busy, overrun, timeout_tick}, 4'b0000);
    endtask

    initial begin
        op_tab[0] = 8'h20; op_tab[1] = 8'h22; op_tab[2] = 8'h24;
        op_tab[3] = 8'h25; op_tab[4] = 8'h26;
        reset = 1'b1; rx_done_tick = 1'b0; tx_done_tick = 1'b0; rx_data = 8'h00;
        idle(3);
        reset = 1'b0;
        check_reset_state("reset");

        // Basic frame
        send_byte(8'h05, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h20, 1'b0);
        expect_tx("basic", 8'h05, 8'h03, 8'h20);
        check("basic.value", tx_data, 8'h08);
        finish_tx("basic", 8'h08, 3);

        // tx_done in WAIT_A is ignored
        tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
        check("stray_txd.busy", busy, 1'b0);

        // Back-to-back frames
        send_byte(8'h06, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h22, 1'b0);
        expect_tx("b2b1", 8'h06, 8'h02, 8'h22);
        check("b2b1.value", tx_data, 8'h04);
        finish_tx("b2b1", 8'h04, 1);
        send_byte(8'h0C, 1'b0); send_byte(8'h0A, 1'b0); send_byte(8'h24, 1'b0);
        expect_tx("b2b2", 8'h0C, 8'h0A, 8'h24);
        check("b2b2.value", tx_data, 8'h08);
        finish_tx("b2b2", 8'h08, 0);
        check("b2b.overrun", overrun, 1'b0);

        // Overrun: byte during WAIT_TX is dropped
        send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h20, 1'b0);
        expect_tx("ovr_pre", 8'h01, 8'h01, 8'h20);
        send_byte(8'h55, 1'b0);
        check("ovr.flag", overrun, 1'b1);
        check("ovr.alu_a", alu_a, 8'h01);
        check("ovr.tx_data", tx_data, 8'h02);
        finish_tx("ovr_pre", 8'h02, 2);
        send_byte(8'h01, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h20, 1'b0);
        expect_tx("ovr_next", 8'h01, 8'h01, 8'h20);
        check("ovr_next.value", tx_data, 8'h02);
        check("ovr.sticky", overrun, 1'b1);

        // Simultaneous rx + tx_done in WAIT_TX starts the next frame
        send_byte(8'h07, 1'b1);
        check("simul.alu_a", alu_a, 8'h07);
        check("simul.busy", busy, 1'b0);
        check("simul.overrun", overrun, 1'b1);
        send_byte(8'h01, 1'b0); send_byte(8'h20, 1'b0);
        expect_tx("simul", 8'h07, 8'h01, 8'h20);
        check("simul.value", tx_data, 8'h08);
        finish_tx("simul", 8'h08, 1);

        // Reset in WAIT_OP
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        reset = 1'b1; step(); reset = 1'b0;
        check_reset_state("rst_op");
        send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h20, 1'b0);
        expect_tx("rst_op_next", 8'h03, 8'h04, 8'h20);
        finish_tx("rst_op_next", 8'h07, 0);

        // Reset in WAIT_TX
        send_byte(8'h09, 1'b0); send_byte(8'h08, 1'b0); send_byte(8'h22, 1'b0);
        expect_tx("rst_tx_pre", 8'h09, 8'h08, 8'h22);
        reset = 1'b1; step(); reset = 1'b0;
        check_reset_state("rst_tx");
        send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h25, 1'b0);
        expect_tx("rst_tx_next", 8'h10, 8'h20, 8'h25);
        check("rst_tx_next.value", tx_data, 8'h30);
        finish_tx("rst_tx_next", 8'h30, 0);

        // Timeout after TO idle cycles in WAIT_B
        send_byte(8'h09, 1'b0);
        pulses = 0;
        for (int i = 0; i < TO - 1; i++) begin
            step();
            if (timeout_tick) pulses++;
        end
        check("to.early", pulses, 0);
        step();
        check("to.tick", timeout_tick, 1'b1);
        check("to.alu_a_kept", alu_a, 8'h09);
        step();
        check("to.tick_once", timeout_tick, 1'b0);
        send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h20, 1'b0);
        expect_tx("to_next", 8'h02, 8'h03, 8'h20);
        check("to_next.value", tx_data, 8'h05);
        finish_tx("to_next", 8'h05, 0);

        // Bytes landing exactly on the expiry cycle are accepted
        pulses = 0;
        send_byte(8'h09, 1'b0);
        for (int i = 0; i < TO - 1; i++) begin
            step();
            if (timeout_tick) pulses++;
        end
        send_byte(8'h04, 1'b0);
        if (timeout_tick) pulses++;
        for (int i = 0; i < TO - 1; i++) begin
            step();
            if (timeout_tick) pulses++;
        end
        send_byte(8'h20, 1'b0);
        if (timeout_tick) pulses++;
        check("expiry.no_tick", pulses, 0);
        expect_tx("expiry", 8'h09, 8'h04, 8'h20);
        check("expiry.value", tx_data, 8'h0D);
        finish_tx("expiry", 8'h0D, 0);

        // Random frames with gaps below the timeout and stray tx_done ticks
        for (int n = 0; n < 25; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                             : (op_tab[$urandom_range(0, 4)] | 8'($urandom_range(0, 3) << 6));
            g1   = $urandom_range(0, TO - 2);
            g2   = $urandom_range(0, TO - 2);
            hold = $urandom_range(0, 4);
            ex   = alu_model(ra, rb, ro[5:0]);
            send_byte(ra, 1'($urandom));
            idle(g1);
            send_byte(rb, 1'($urandom));
            idle(g2);
            send_byte(ro, 1'($urandom));
            expect_tx("rand", ra, rb, ro);
            finish_tx("rand", ex, hold);
            idle($urandom_range(0, 20));
        end
        check("rand.overrun", overrun, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
